writeback_arbiter: RTL and testbench

Arbitrates the register file's single write port among three requesters: ALU writeback, load-unit writeback, and the debug/UART register-poke path. It sits directly in front of the register file and drives its `writeRegister`, `rd` and `dataToWrite` inputs from a registered output stage. Grants follow a fixed priority. An aging counter per requester bounds how long any requester can wait.

---
 rtl/writeback_arbiter_pkg.sv | 17 +
 rtl/writeback_arbiter_if.sv | 33 +++
 rtl/writeback_arbiter_wait_counter.sv | 29 ++
 rtl/writeback_arbiter.sv | 112 +++++++++++
 tb/tb_writeback_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared register-file definitions and requester indices for the writeback arbiter.
// Also hosts the small helper used to detect contended cycles.
package riscx_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int WAIT_W     = 4;

  typedef enum logic [1:0] {
    REQ_ALU  = 2'd0,
    REQ_LOAD = 2'd1,
    REQ_DBG  = 2'd2
  } req_e;

  function automatic logic multi_valid(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction
endpackage

// File: rtl/writeback_arbiter_if.sv
// Requester handshakes plus the registered register-file write port.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// the requester keeps valid/Rd/Data stable until then, and ready never rises without valid.
interface writeback_arbiter_if;
  import riscx_pkg::*;

  logic                  aluValid;
  logic [REG_ADDR_W-1:0] aluRd;
  logic [XLEN-1:0]       aluData;
  logic                  aluReady;
  logic                  loadValid;
  logic [REG_ADDR_W-1:0] loadRd;
  logic [XLEN-1:0]       loadData;
  logic                  loadReady;
  logic                  dbgValid;
  logic [REG_ADDR_W-1:0] dbgRd;
  logic [XLEN-1:0]       dbgData;
  logic                  dbgReady;
  logic                  writeRegister;
  logic [REG_ADDR_W-1:0] rd;
  logic [XLEN-1:0]       dataToWrite;
  logic [15:0]           conflictCount;

  modport master (
    output aluValid, aluRd, aluData, loadValid, loadRd, loadData, dbgValid, dbgRd, dbgData,
    input  aluReady, loadReady, dbgReady, writeRegister, rd, dataToWrite, conflictCount
  );

  modport slave (
    input  aluValid, aluRd, aluData, loadValid, loadRd, loadData, dbgValid, dbgRd, dbgData,
    output aluReady, loadReady, dbgReady, writeRegister, rd, dataToWrite, conflictCount
  );
endinterface

// File: rtl/writeback_arbiter_wait_counter.sv
// Saturating per-requester wait counter; urgent while the request is still pending
// and the counter has reached the starvation limit.
module wait_counter
  import riscx_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inc,
  input  logic              clr,
  input  logic              active,
  output logic              urgent,
  output logic [WAIT_W-1:0] count
);
  localparam logic [WAIT_W-1:0] LIMIT_V = WAIT_W'(LIMIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LIMIT_V)) begin
      count <= count + 1'b1;
    end
  end

  assign urgent = active && (count == LIMIT_V);
endmodule

// File: rtl/writeback_arbiter.sv
// Fixed-priority arbiter for the single register-file write port, with starvation
// aging and a registered write stage feeding the register file.
module writeback_arbiter
  import riscx_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input logic               clock,
  input logic               reset,
  writeback_arbiter_if.slave bus
);
  logic [2:0]            valid;
  logic [2:0]            ready;
  logic [2:0]            urgent;
  logic [WAIT_W-1:0]     wait_alu;
  logic [WAIT_W-1:0]     wait_load;
  logic [WAIT_W-1:0]     wait_dbg;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;
  logic                  wr_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]       data_q;
  logic [15:0]           conflict_q;

  assign valid = {bus.dbgValid, bus.loadValid, bus.aluValid};

  wait_counter #(.LIMIT(STARVE_LIMIT)) u_wait_alu (
    .clock  (clock),
    .reset  (reset),
    .inc    (valid[REQ_ALU] & ~ready[REQ_ALU]),
    .clr    (~valid[REQ_ALU] | ready[REQ_ALU]),
    .active (valid[REQ_ALU]),
    .urgent (urgent[REQ_ALU]),
    .count  (wait_alu)
  );

  wait_counter #(.LIMIT(STARVE_LIMIT)) u_wait_load (
    .clock  (clock),
    .reset  (reset),
    .inc    (valid[REQ_LOAD] & ~ready[REQ_LOAD]),
    .clr    (~valid[REQ_LOAD] | ready[REQ_LOAD]),
    .active (valid[REQ_LOAD]),
    .urgent (urgent[REQ_LOAD]),
    .count  (wait_load)
  );

  wait_counter #(.LIMIT(STARVE_LIMIT)) u_wait_dbg (
    .clock  (clock),
    .reset  (reset),
    .inc    (valid[REQ_DBG] & ~ready[REQ_DBG]),
    .clr    (~valid[REQ_DBG] | ready[REQ_DBG]),
    .active (valid[REQ_DBG]),
    .urgent (urgent[REQ_DBG]),
    .count  (wait_dbg)
  );

  // Urgent requesters win in reverse order (debug first) so the least favoured
  // source in normal priority is rescued first.
  always_comb begin
    ready = '0;
    if (urgent[REQ_DBG])       ready[REQ_DBG]  = 1'b1;
    else if (urgent[REQ_LOAD]) ready[REQ_LOAD] = 1'b1;
    else if (urgent[REQ_ALU])  ready[REQ_ALU]  = 1'b1;
    else if (valid[REQ_ALU])   ready[REQ_ALU]  = 1'b1;
    else if (valid[REQ_LOAD])  ready[REQ_LOAD] = 1'b1;
    else if (valid[REQ_DBG])   ready[REQ_DBG]  = 1'b1;
  end

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    if (ready[REQ_DBG]) begin
      sel_rd   = bus.dbgRd;
      sel_data = bus.dbgData;
    end else if (ready[REQ_LOAD]) begin
      sel_rd   = bus.loadRd;
      sel_data = bus.loadData;
    end else if (ready[REQ_ALU]) begin
      sel_rd   = bus.aluRd;
      sel_data = bus.aluData;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q       <= 1'b0;
      rd_q       <= '0;
      data_q     <= '0;
      conflict_q <= '0;
    end else begin
      if (|ready) begin
        rd_q   <= sel_rd;
        data_q <= sel_data;
        // x0 writes are accepted to unblock the requester but never reach the file.
        wr_q   <= (sel_rd != '0);
      end else begin
        wr_q <= 1'b0;
      end
      if (multi_valid(valid) && (conflict_q != 16'hFFFF)) begin
        conflict_q <= conflict_q + 16'd1;
      end
    end
  end

  assign bus.aluReady      = ready[REQ_ALU];
  assign bus.loadReady     = ready[REQ_LOAD];
  assign bus.dbgReady      = ready[REQ_DBG];
  assign bus.writeRegister = wr_q;
  assign bus.rd            = rd_q;
  assign bus.dataToWrite   = data_q;
  assign bus.conflictCount = conflict_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: a spec-level model checked every cycle
// plus literal expectations taken from the test plan.
module tb_writeback_arbiter;
  localparam int L = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  writeback_arbiter_if bus ();

  writeback_arbiter #(.STARVE_LIMIT(L)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  // Model state: index 0 = ALU, 1 = load, 2 = debug.
  int          m_wait [3] = '{0, 0, 0};
  logic        m_wr       = 1'b0;
  logic [4:0]  m_rd       = '0;
  logic [31:0] m_data     = '0;
  int          m_conf     = 0;
  logic [36:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [2:0] cur_valids();
    return {bus.dbgValid, bus.loadValid, bus.aluValid};
  endfunction

  function automatic int exp_grant(input logic [2:0] v);
    int g = -1;
    for (int i = 2; i >= 0; i--) if (g < 0 && v[i] && m_wait[i] == L) g = i;
    for (int i = 0; i < 3; i++) if (g < 0 && v[i]) g = i;
    return g;
  endfunction

  function automatic logic [4:0] rd_of(input int g);
    case (g)
      0: return bus.aluRd;
      1: return bus.loadRd;
      default: return bus.dbgRd;
    endcase
  endfunction

  function automatic logic [31:0] data_of(input int g);
    case (g)
      0: return bus.aluData;
      1: return bus.loadData;
      default: return bus.dbgData;
    endcase
  endfunction

  // Model update on each edge, from the spec's aging and grant rules.
  always @(posedge clock or posedge reset) begin
    logic [2:0] v;
    int g;
    int nv;
    if (reset) begin
      m_wait = '{0, 0, 0};
      m_wr   = 1'b0;
      m_rd   = '0;
      m_data = '0;
      m_conf = 0;
      exp_q.delete();
    end else begin
      v  = cur_valids();
      g  = exp_grant(v);
      nv = int'(v[0]) + int'(v[1]) + int'(v[2]);
      for (int i = 0; i < 3; i++) begin
        if (!v[i] || i == g) m_wait[i] = 0;
        else if (m_wait[i] < L) m_wait[i] = m_wait[i] + 1;
      end
      if (g >= 0) begin
        m_rd   = rd_of(g);
        m_data = data_of(g);
        m_wr   = (m_rd != 5'd0);
        if (m_wr) exp_q.push_back({m_rd, m_data});
      end else begin
        m_wr = 1'b0;
      end
      if (nv >= 2 && m_conf < 65535) m_conf = m_conf + 1;
    end
  end

  // Per-cycle compare against the model plus a write scoreboard.
  always @(negedge clock) begin
    logic [2:0] exp_ready;
    logic [36:0] e;
    int g;
    if (chk_on) begin
      g = exp_grant(cur_valids());
      exp_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
      check("ready_vec", 32'({bus.dbgReady, bus.loadReady, bus.aluReady}), 32'(exp_ready));
      check("write_en", 32'(bus.writeRegister), 32'(m_wr));
      check("rd", 32'(bus.rd), 32'(m_rd));
      check("data", bus.dataToWrite, m_data);
      check("conflict", 32'(bus.conflictCount), 32'(m_conf));
      if (bus.writeRegister) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_write", 32'(bus.rd), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("sb_write", {27'd0, bus.rd} ^ bus.dataToWrite, {27'd0, e[36:32]} ^ e[31:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int idx, input logic vld, input logic [4:0] r, input logic [31:0] d);
    case (idx)
      0: begin bus.aluValid = vld;  bus.aluRd = r;  bus.aluData = d;  end
      1: begin bus.loadValid = vld; bus.loadRd = r; bus.loadData = d; end
      default: begin bus.dbgValid = vld; bus.dbgRd = r; bus.dbgData = d; end
    endcase
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 5'd0, 32'd0);
  endtask

  int gcnt [3];

  initial begin
    idle_all();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_wr", 32'(bus.writeRegister), 32'd0);
    check("reset_rd", 32'(bus.rd), 32'd0);
    check("reset_data", bus.dataToWrite, 32'd0);
    check("reset_conflict", 32'(bus.conflictCount), 32'd0);
    chk_on = 1'b1;
    step();

    // Single ALU write.
    drive(0, 1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge clock);
    check("t1_alu_ready", 32'(bus.aluReady), 32'd1);
    step();
    idle_all();
    @(negedge clock);
    check("t1_wr", 32'(bus.writeRegister), 32'd1);
    check("t1_rd", 32'(bus.rd), 32'd5);
    check("t1_data", bus.dataToWrite, 32'hDEADBEEF);
    step();
    @(negedge clock);
    check("t1_wr_drop", 32'(bus.writeRegister), 32'd0);
    step();

    // ALU and debug contend: debug becomes urgent on the fifth cycle.
    drive(0, 1'b1, 5'd7, 32'h1111);
    drive(2, 1'b1, 5'd9, 32'h2222);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      check("t2_alu_ready", 32'(bus.aluReady), (c <= 4) ? 32'd1 : 32'd0);
      check("t2_dbg_ready", 32'(bus.dbgReady), (c == 5) ? 32'd1 : 32'd0);
      step();
    end
    idle_all();
    @(negedge clock);
    check("t2_conflict", 32'(bus.conflictCount), 32'd5);
    check("t2_rd", 32'(bus.rd), 32'd9);
    check("t2_data", bus.dataToWrite, 32'h2222);
    step();

    // Load write to x0 is accepted but not written.
    drive(1, 1'b1, 5'd0, 32'h1234);
    @(negedge clock);
    check("t3_load_ready", 32'(bus.loadReady), 32'd1);
    step();
    idle_all();
    @(negedge clock);
    check("t3_wr", 32'(bus.writeRegister), 32'd0);
    check("t3_rd", 32'(bus.rd), 32'd0);
    check("t3_data", bus.dataToWrite, 32'h1234);
    step();

    // All three contend for 12 cycles; every requester must get through.
    gcnt = '{0, 0, 0};
    drive(0, 1'b1, 5'd1, 32'hA1);
    drive(1, 1'b1, 5'd2, 32'hB2);
    drive(2, 1'b1, 5'd3, 32'hC3);
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      gcnt[0] += int'(bus.aluReady);
      gcnt[1] += int'(bus.loadReady);
      gcnt[2] += int'(bus.dbgReady);
      step();
    end
    idle_all();
    check("t4_alu_served", 32'(gcnt[0] > 0), 32'd1);
    check("t4_load_served", 32'(gcnt[1] > 0), 32'd1);
    check("t4_dbg_served", 32'(gcnt[2] > 0), 32'd1);
    check("t4_total_grants", 32'(gcnt[0] + gcnt[1] + gcnt[2]), 32'd12);
    @(negedge clock);
    check("t4_conflict", 32'(bus.conflictCount), 32'd17);
    step();

    // Asynchronous reset while debug is urgent.
    drive(0, 1'b1, 5'd4, 32'hAAAA);
    drive(2, 1'b1, 5'd6, 32'hBBBB);
    repeat (4) step();
    #1;
    check("t5_dbg_urgent", 32'(bus.dbgReady), 32'd1);
    reset = 1'b1;
    #1;
    check("t5_rst_wr", 32'(bus.writeRegister), 32'd0);
    check("t5_rst_rd", 32'(bus.rd), 32'd0);
    check("t5_rst_data", bus.dataToWrite, 32'd0);
    check("t5_rst_conflict", 32'(bus.conflictCount), 32'd0);
    check("t5_rst_wait_dbg", 32'(dut.wait_dbg), 32'd0);
    check("t5_rst_alu_first", 32'(bus.aluReady), 32'd1);
    @(negedge clock);
    #1;
    drive(0, 1'b0, 5'd0, 32'd0);
    reset = 1'b0;
    #1;
    check("t5_dbg_after_reset", 32'(bus.dbgReady), 32'd1);
    step();
    idle_all();
    @(negedge clock);
    check("t5_rd", 32'(bus.rd), 32'd6);
    step();

    // Saturation of the conflict counter.
    force dut.conflict_q = 16'hFFFE;
    m_conf = 65534;
    #1;
    release dut.conflict_q;
    drive(0, 1'b1, 5'd10, 32'h55);
    drive(1, 1'b1, 5'd11, 32'h66);
    repeat (3) step();
    @(negedge clock);
    check("t6_conflict_sat", 32'(bus.conflictCount), 32'h0000FFFF);
    step();
    idle_all();
    step();
    @(negedge clock);
    check("t6_conflict_hold", 32'(bus.conflictCount), 32'h0000FFFF);
    chk_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
